// File: rtl/gerenciador_de_acesso.sv
// ---------------------------------------------------------------------------
// gerenciador_de_acesso
// Two-interface access arbiter with a bounded hold time.
//
// An upstream comparator supplies the priority verdict (prio_s) that settles
// simultaneous requests. The holder keeps access until it releases, drops its
// request, or uses up HOLD_MAX consecutive grant cycles. Every grant ends
// with a single COOLDOWN cycle before the next arbitration.
//
// Optional feature: define PREEMPCAO_EN to let the other interface take
// access away from the holder. It preempts when it is requesting and prio_s
// names it strictly (a tie does not count). Without the macro, the holder
// keeps access until it releases or times out.
//
// Parameters:
//   HOLD_MAX        maximum consecutive grant cycles per holder (1..255)
// Ports:
//   clk             single clock, rising edge
//   rst_n           asynchronous active-low reset
//   req0/req1       access requests from interface 0 / 1
//   user0/user1     user code presented by interface 0 / 1
//   prio_s          priority verdict: 10 = if0 wins, 01 = if1 wins, else tie
//   release0/1      holder gives up access
//   grant0/grant1   access granted (one-hot or zero)
//   owner_user      user code latched at grant, 000 when no grant
//   timeout         one-cycle pulse, holder hit HOLD_MAX
//   preempted       one-cycle pulse, holder was preempted
//   preempted_user  code of the last preempted holder
// ---------------------------------------------------------------------------
//  state    | meaning
//  IDLE     | no holder, arbitrate requests each cycle
//  GRANT0   | interface 0 holds access
//  GRANT1   | interface 1 holds access
//  COOLDOWN | one dead cycle after any grant ends
// ---------------------------------------------------------------------------
module gerenciador_de_acesso #(
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [2:0] user0,
    input  logic [2:0] user1,
    input  logic [1:0] prio_s,
    input  logic       release0,
    input  logic       release1,
    output logic       grant0,
    output logic       grant1,
    output logic [2:0] owner_user,
    output logic       timeout,
    output logic       preempted,
    output logic [2:0] preempted_user
);

`ifdef PREEMPCAO_EN
    localparam bit PREEMPT_ON = 1'b1;
`else
    localparam bit PREEMPT_ON = 1'b0;
`endif

    localparam logic [7:0] HOLD_LIM = HOLD_MAX[7:0];

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, COOLDOWN} state_t;

    state_t     state;
    logic [7:0] hold_cnt;

    assign grant0 = (state == GRANT0);
    assign grant1 = (state == GRANT1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            hold_cnt       <= 8'd0;
            owner_user     <= 3'b000;
            timeout        <= 1'b0;
            preempted      <= 1'b0;
            preempted_user <= 3'b000;
        end else begin
            timeout   <= 1'b0;
            preempted <= 1'b0;
            case (state)
                IDLE: begin
                    // Interface 0 wins unless interface 1 is also requesting
                    // and the comparator names it strictly.
                    if (req0 && !(req1 && prio_s == 2'b01)) begin
                        state      <= GRANT0;
                        owner_user <= user0;
                        hold_cnt   <= 8'd1;
                    end else if (req1) begin
                        state      <= GRANT1;
                        owner_user <= user1;
                        hold_cnt   <= 8'd1;
                    end
                end
                GRANT0: begin
                    // Preemption outranks release and timeout of the holder.
                    if (PREEMPT_ON && req1 && prio_s == 2'b01) begin
                        state          <= GRANT1;
                        owner_user     <= user1;
                        hold_cnt       <= 8'd1;
                        preempted      <= 1'b1;
                        preempted_user <= owner_user;
                    end else if (release0 || !req0) begin
                        state      <= COOLDOWN;
                        owner_user <= 3'b000;
                        hold_cnt   <= 8'd0;
                    end else if (hold_cnt == HOLD_LIM) begin
                        state      <= COOLDOWN;
                        owner_user <= 3'b000;
                        hold_cnt   <= 8'd0;
                        timeout    <= 1'b1;
                    end else if (hold_cnt != 8'hFF) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                GRANT1: begin
                    if (PREEMPT_ON && req0 && prio_s == 2'b10) begin
                        state          <= GRANT0;
                        owner_user     <= user0;
                        hold_cnt       <= 8'd1;
                        preempted      <= 1'b1;
                        preempted_user <= owner_user;
                    end else if (release1 || !req1) begin
                        state      <= COOLDOWN;
                        owner_user <= 3'b000;
                        hold_cnt   <= 8'd0;
                    end else if (hold_cnt == HOLD_LIM) begin
                        state      <= COOLDOWN;
                        owner_user <= 3'b000;
                        hold_cnt   <= 8'd0;
                        timeout    <= 1'b1;
                    end else if (hold_cnt != 8'hFF) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                COOLDOWN: begin
                    state <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    owner_user <= 3'b000;
                    hold_cnt   <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gerenciador_de_acesso.sv
// ---------------------------------------------------------------------------
// tb_gerenciador_de_acesso
// Scripted scoreboard bench for the access arbiter (HOLD_MAX = 4). Each
// stimulus row pushes the output vector expected after the next rising edge.
// The calling test pops that vector and compares it against the DUT.
// Expectations follow PREEMPCAO_EN when the macro is defined.
// ---------------------------------------------------------------------------
module tb_gerenciador_de_acesso;

`ifdef PREEMPCAO_EN
    localparam bit PRE_ON = 1'b1;
`else
    localparam bit PRE_ON = 1'b0;
`endif

    localparam int unsigned HM = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1, release0, release1;
    logic [2:0] user0, user1;
    logic [1:0] prio_s;
    logic       grant0, grant1, timeout, preempted;
    logic [2:0] owner_user, preempted_user;

    int checks   = 0;
    int failures = 0;

    logic [9:0] sb[$];
    logic [9:0] e;

    // {grant0, grant1, owner_user, timeout, preempted, preempted_user}
    wire [9:0] obs = {grant0, grant1, owner_user, timeout, preempted, preempted_user};

    typedef struct packed {
        logic       r0;
        logic       r1;
        logic [2:0] u0;
        logic [2:0] u1;
        logic [1:0] p;
        logic       rl0;
        logic       rl1;
        logic [9:0] e;
    } row_t;

    gerenciador_de_acesso #(.HOLD_MAX(HM)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req0           (req0),
        .req1           (req1),
        .user0          (user0),
        .user1          (user1),
        .prio_s         (prio_s),
        .release0       (release0),
        .release1       (release1),
        .grant0         (grant0),
        .grant1         (grant1),
        .owner_user     (owner_user),
        .timeout        (timeout),
        .preempted      (preempted),
        .preempted_user (preempted_user)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] ex(input logic g0, input logic g1, input logic [2:0] own,
                                      input logic to, input logic pre, input logic [2:0] pu);
        return {g0, g1, own, to, pre, pu};
    endfunction

    function automatic row_t rw(input logic r0, input logic r1, input logic [2:0] u0,
                                input logic [2:0] u1, input logic [1:0] p,
                                input logic rl0, input logic rl1, input logic [9:0] x);
        row_t r;
        r.r0 = r0; r.r1 = r1; r.u0 = u0; r.u1 = u1; r.p = p;
        r.rl0 = rl0; r.rl1 = rl1; r.e = x;
        return r;
    endfunction

    // Apply one row, record its expectation, let one rising edge pass.
    task automatic drive(input row_t r);
        req0 = r.r0; req1 = r.r1; user0 = r.u0; user1 = r.u1;
        prio_s = r.p; release0 = r.rl0; release1 = r.rl1;
        sb.push_back(r.e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        row_t rows[$];
        #2;
        sb.push_back(ex(0, 0, 0, 0, 0, 0));
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL reset_state got=%b expected=%b", obs, e);
        end
        // Requests while reset is held must not be granted.
        rows.push_back(rw(1, 1, 7, 2, 2'b01, 0, 0, ex(0, 0, 0, 0, 0, 0)));
        rows.push_back(rw(1, 1, 7, 2, 2'b01, 0, 0, ex(0, 0, 0, 0, 0, 0)));
        foreach (rows[i]) begin
            drive(rows[i]);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL reset_hold row%0d got=%b expected=%b", i, obs, e);
            end
        end
        @(negedge clk);
        req0 = 0; req1 = 0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_timeout();
        row_t rows[$];
        for (int k = 0; k < 4; k++)
            rows.push_back(rw(1, 0, 6, 0, 2'b00, 0, 0, ex(1, 0, 6, 0, 0, 0)));
        rows.push_back(rw(1, 0, 6, 0, 2'b00, 0, 0, ex(0, 0, 0, 1, 0, 0)));  // timeout, COOLDOWN
        rows.push_back(rw(1, 0, 6, 0, 2'b00, 0, 0, ex(0, 0, 0, 0, 0, 0)));  // IDLE
        rows.push_back(rw(1, 0, 6, 0, 2'b00, 0, 0, ex(1, 0, 6, 0, 0, 0)));  // re-grant
        rows.push_back(rw(0, 0, 6, 0, 2'b00, 0, 0, ex(0, 0, 0, 0, 0, 0)));
        rows.push_back(rw(0, 0, 6, 0, 2'b00, 0, 0, ex(0, 0, 0, 0, 0, 0)));
        foreach (rows[i]) begin
            drive(rows[i]);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL timeout row%0d got=%b expected=%b", i, obs, e);
            end
        end
    endtask

    task automatic test_priority();
        row_t rows[$];
        rows.push_back(rw(1, 1, 5, 3, 2'b01, 0, 0, ex(0, 1, 3, 0, 0, 0)));
        rows.push_back(rw(1, 1, 5, 7, 2'b01, 0, 0, ex(0, 1, 3, 0, 0, 0)));  // user1 change ignored
        rows.push_back(rw(1, 1, 5, 7, 2'b01, 1, 0, ex(0, 1, 3, 0, 0, 0)));  // non-holder release ignored
        rows.push_back(rw(1, 1, 5, 7, 2'b01, 0, 1, ex(0, 0, 0, 0, 0, 0)));  // release1 -> COOLDOWN
        rows.push_back(rw(1, 0, 5, 7, 2'b01, 0, 0, ex(0, 0, 0, 0, 0, 0)));  // IDLE
        rows.push_back(rw(1, 0, 5, 7, 2'b01, 0, 0, ex(1, 0, 5, 0, 0, 0)));  // grant0
        rows.push_back(rw(0, 0, 5, 7, 2'b00, 0, 0, ex(0, 0, 0, 0, 0, 0)));
        rows.push_back(rw(0, 0, 5, 7, 2'b00, 0, 0, ex(0, 0, 0, 0, 0, 0)));
        foreach (rows[i]) begin
            drive(rows[i]);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL priority row%0d got=%b expected=%b", i, obs, e);
            end
        end
    endtask

    task automatic test_tie();
        row_t rows[$];
        rows.push_back(rw(1, 1, 2, 4, 2'b11, 0, 0, ex(1, 0, 2, 0, 0, 0)));
        rows.push_back(rw(1, 1, 2, 4, 2'b00, 0, 0, ex(1, 0, 2, 0, 0, 0)));
        rows.push_back(rw(0, 1, 2, 4, 2'b00, 0, 0, ex(0, 0, 0, 0, 0, 0)));  // req0 drop
        rows.push_back(rw(0, 1, 2, 4, 2'b00, 0, 0, ex(0, 0, 0, 0, 0, 0)));  // IDLE regardless of req1
        rows.push_back(rw(1, 1, 2, 4, 2'b00, 0, 0, ex(1, 0, 2, 0, 0, 0)));  // tie 00 -> if0
        rows.push_back(rw(1, 1, 2, 4, 2'b10, 1, 0, ex(0, 0, 0, 0, 0, 0)));
        rows.push_back(rw(0, 0, 2, 4, 2'b00, 0, 0, ex(0, 0, 0, 0, 0, 0)));
        rows.push_back(rw(1, 1, 2, 4, 2'b10, 0, 0, ex(1, 0, 2, 0, 0, 0)));  // prio 10 -> if0
        rows.push_back(rw(0, 0, 2, 4, 2'b00, 0, 0, ex(0, 0, 0, 0, 0, 0)));
        rows.push_back(rw(0, 0, 2, 4, 2'b00, 0, 0, ex(0, 0, 0, 0, 0, 0)));
        foreach (rows[i]) begin
            drive(rows[i]);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL tie row%0d got=%b expected=%b", i, obs, e);
            end
        end
    endtask

    task automatic test_release_at_limit();
        row_t rows[$];
        for (int k = 0; k < 4; k++)
            rows.push_back(rw(1, 0, 1, 0, 2'b00, 0, 0, ex(1, 0, 1, 0, 0, 0)));
        rows.push_back(rw(1, 0, 1, 0, 2'b00, 1, 0, ex(0, 0, 0, 0, 0, 0)));  // release wins, no timeout
        rows.push_back(rw(0, 0, 1, 0, 2'b00, 0, 0, ex(0, 0, 0, 0, 0, 0)));
        foreach (rows[i]) begin
            drive(rows[i]);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL release_at_limit row%0d got=%b expected=%b", i, obs, e);
            end
        end
    endtask

    task automatic test_preempt();
        row_t rows[$];
        rows.push_back(rw(1, 0, 1, 5, 2'b00, 0, 0, ex(1, 0, 1, 0, 0, 0)));
        rows.push_back(rw(1, 1, 1, 5, 2'b01, 0, 0,
                          PRE_ON ? ex(0, 1, 5, 0, 1, 1) : ex(1, 0, 1, 0, 0, 0)));
        rows.push_back(rw(1, 1, 1, 5, 2'b01, 0, 0,
                          PRE_ON ? ex(0, 1, 5, 0, 0, 1) : ex(1, 0, 1, 0, 0, 0)));
        // Holder release in the same cycle as a preemption request.
        rows.push_back(rw(1, 1, 3, 5, 2'b10, 0, 1,
                          PRE_ON ? ex(1, 0, 3, 0, 1, 5) : ex(1, 0, 1, 0, 0, 0)));
        rows.push_back(rw(0, 0, 3, 5, 2'b00, 1, 0,
                          PRE_ON ? ex(0, 0, 0, 0, 0, 5) : ex(0, 0, 0, 0, 0, 0)));
        rows.push_back(rw(0, 0, 3, 5, 2'b00, 0, 0,
                          PRE_ON ? ex(0, 0, 0, 0, 0, 5) : ex(0, 0, 0, 0, 0, 0)));
        foreach (rows[i]) begin
            drive(rows[i]);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL preempt row%0d got=%b expected=%b", i, obs, e);
            end
        end
    endtask

    task automatic test_async_reset();
        row_t       rows[$];
        logic [2:0] pu;
        pu = PRE_ON ? 3'd5 : 3'd0;
        rows.push_back(rw(0, 1, 0, 3, 2'b00, 0, 0, ex(0, 1, 3, 0, 0, pu)));
        rows.push_back(rw(0, 1, 0, 3, 2'b00, 0, 0, ex(0, 1, 3, 0, 0, pu)));
        foreach (rows[i]) begin
            drive(rows[i]);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL async_reset_grant row%0d got=%b expected=%b", i, obs, e);
            end
        end
        // Assert reset between edges; outputs must clear without a clock edge.
        #2;
        rst_n = 1'b0;
        sb.push_back(ex(0, 0, 0, 0, 0, 0));
        #1;
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL async_reset_drop got=%b expected=%b", obs, e);
        end
        sb.push_back(ex(0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL async_reset_held got=%b expected=%b", obs, e);
        end
        #2;
        rst_n = 1'b1;
        sb.push_back(ex(0, 0, 0, 0, 0, 0));
        #1;
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL async_reset_release got=%b expected=%b", obs, e);
        end
        // First edge with rst_n high arbitrates the pending req1.
        sb.push_back(ex(0, 1, 3, 0, 0, 0));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL async_reset_first_grant got=%b expected=%b", obs, e);
        end
        rows.delete();
        rows.push_back(rw(0, 0, 0, 3, 2'b00, 0, 0, ex(0, 0, 0, 0, 0, 0)));
        rows.push_back(rw(0, 0, 0, 3, 2'b00, 0, 0, ex(0, 0, 0, 0, 0, 0)));
        foreach (rows[i]) begin
            drive(rows[i]);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL async_reset_tail row%0d got=%b expected=%b", i, obs, e);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req0 = 0; req1 = 0; release0 = 0; release1 = 0;
        user0 = 0; user1 = 0; prio_s = 2'b00;
        test_reset();
        test_timeout();
        test_priority();
        test_tie();
        test_release_at_limit();
        test_preempt();
        test_async_reset();
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
